downsampler_2x2: RTL and testbench
==================================

# downsampler_2x2

Two-to-one spatial downsampler feeding the upsampling stage. Consumes a raster-order 8-bit pixel stream (IN_WIDTH x IN_HEIGHT, default 800x600) with a per-pixel valid strobe. Emits one pixel per 2x2 input block (default 400x300), with output row/column coordinates. Output is a valid-qualified stream with no backpressure; the downstream FIFO/upsampler absorbs it.

## Interface
- IN_WIDTH, 800, input pixels per row; must be even, at most 2046
- IN_HEIGHT, 600, input rows per frame; must be even, at most 2046
- DATA_W, 8, pixel width in bits
- clock  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- valid  in  1  din is a valid pixel this cycle
- sof  in  1  start of frame; qualified by valid; marks pixel (0,0)
- din  in  DATA_W  input pixel, raster order
- dataout  out  DATA_W  downsampled pixel
- validout  out  1  dataout/rownum/colnum valid this cycle (single-cycle strobe)
- rownum  out  10  output row of dataout, 0..IN_HEIGHT/2-1
- colnum  out  10  output column of dataout, 0..IN_WIDTH/2-1

## Operation
- Internal input counters: in_col (0..IN_WIDTH-1) and in_row (0..IN_HEIGHT-1). Both advance only on valid; in_col wraps to 0 and increments in_row; in_row wraps to 0 after the last pixel of the frame.
- sof with valid forces the current pixel to be treated as (0,0): counters load col=1,row=0 after the cycle and any partial pair/line state is discarded. sof without valid is ignored.
- Horizontal pair: on even in_col, latch din in pair_reg. On odd in_col, pair_sum = pair_reg + din (DATA_W+1 bits).
- Even in_row, odd in_col: write pair_sum into line buffer at address in_col>>1 (IN_WIDTH/2 entries x DATA_W+1 bits). No output.
- Odd in_row, odd in_col: total = linebuf[in_col>>1] + pair_sum (DATA_W+2 bits); dataout = (total + 2) >> 2, round half up, never overflows. rownum = in_row>>1, colnum = in_col>>1, validout = 1.
- Gaps in valid hold all state; no timeout.
- Reset mid-frame: counters, pair_reg, outputs cleared; line buffer contents are don't-care, because no read happens before a full even row is rewritten.

## Timing
- All outputs are registered. Reset values: dataout=0, validout=0, rownum=0, colnum=0.
- Latency: validout asserts exactly 1 cycle after the cycle in which the odd-row, odd-column input pixel is accepted.
- Line buffer read is combinational or uses an early-issued synchronous read. The early read is issued at the even-column pixel of the odd row. With a synchronous read, that 1-cycle latency must hold even when valid is high every cycle.
- Throughput: accepts one pixel per cycle sustained. Emits at most one output every 2 cycles, and only during odd input rows.
- Per frame: exactly (IN_WIDTH/2)*(IN_HEIGHT/2) validout pulses (120000 at default).
- Simultaneous reset and valid: reset wins; the pixel is dropped.

## Configuration
- DOWNSAMPLER_AVG_EN defined: 2x2 box average as described, with line buffer.
- Not defined: pure decimation. dataout = the pixel at even in_row, even in_col. No line buffer and no adders are instantiated. validout asserts 1 cycle after that pixel is accepted. Coordinate outputs and per-frame count are unchanged.

## Test plan
- Constant frame 0x80, valid every cycle, sof on first pixel: exactly 120000 validout pulses, all dataout=0x80, last output rownum=299, colnum=399. Then a second frame repeats rownum/colnum from 0,0.
- Columns alternating 0x00/0x01 (even col 0, odd col 1), all rows: average total=2 gives dataout=0x01 everywhere. With DOWNSAMPLER_AVG_EN undefined, dataout=0x00.
- Rounding check:
  - Block {1,1,1,0}: total 3, dataout=1.
  - Block {0,0,0,1}: dataout=0.
  - Block {255,255,255,255}: dataout=255.
  - Block {0,0,1,1}: dataout=1.
- Valid toggled 1-0 randomly across a frame: same output values and count as gap-free run. validout only 1 cycle after each odd/odd accept.
- Assert reset at input pixel (row 101, col 37) for 1 cycle, then restart with sof: outputs 0 during/after reset, next frame fully correct (120000 outputs, correct values).
- sof pulse mid-row 3 at col 200: counters resync; that pixel is treated as (0,0). First output arrives after input row 1, col 1 of the new frame, with rownum=0, colnum=0.

Source files
------------

// File: rtl/downsampler_2x2.sv
// 2x2 spatial downsampler for a raster pixel stream; one output per 2x2 input block.
// Define DOWNSAMPLER_AVG_EN for a rounded 2x2 box average; otherwise even/even decimation.
module downsampler_2x2 #(
    parameter int unsigned IN_WIDTH  = 800,
    parameter int unsigned IN_HEIGHT = 600,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid,
    input  logic              sof,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dataout,
    output logic              validout,
    output logic [9:0]        rownum,
    output logic [9:0]        colnum
);

    localparam logic [10:0] LAST_COL = 11'(IN_WIDTH - 1);
    localparam logic [10:0] LAST_ROW = 11'(IN_HEIGHT - 1);

    logic [10:0] in_col;
    logic [10:0] in_row;
    logic [10:0] col_eff;
    logic [10:0] row_eff;
    logic [10:0] col_next;
    logic [10:0] row_next;
    logic              emit;
    logic [DATA_W-1:0] result;

    // sof re-labels the current pixel as (0,0) before any position-dependent decision
    always_comb begin
        col_eff  = sof ? '0 : in_col;
        row_eff  = sof ? '0 : in_row;
        col_next = col_eff + 11'd1;
        row_next = row_eff;
        if (col_eff == LAST_COL) begin
            col_next = '0;
            row_next = (row_eff == LAST_ROW) ? '0 : row_eff + 11'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_col <= '0;
            in_row <= '0;
        end else if (valid) begin
            in_col <= col_next;
            in_row <= row_next;
        end
    end

`ifdef DOWNSAMPLER_AVG_EN
    localparam int unsigned LB_DEPTH = IN_WIDTH / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [DATA_W-1:0] pair_reg;
    logic [DATA_W:0]   pair_sum;
    logic [DATA_W+1:0] total;
    logic [LB_AW-1:0]  lb_addr;
    logic [DATA_W:0]   linebuf [LB_DEPTH];

    always_comb begin
        lb_addr  = col_eff[LB_AW:1];
        pair_sum = {1'b0, pair_reg} + {1'b0, din};
        total    = {1'b0, linebuf[lb_addr]} + {1'b0, pair_sum};
        // max total + 2 is 4*(2^DATA_W-1)+2, so the shifted result always fits DATA_W
        result   = DATA_W'((total + (DATA_W+2)'(2)) >> 2);
        emit     = valid & row_eff[0] & col_eff[0];
    end

    always_ff @(posedge clock) begin
        if (reset)
            pair_reg <= '0;
        else if (valid && !col_eff[0])
            pair_reg <= din;
    end

    // Contents need no reset: every odd-row read follows a full even-row rewrite
    always_ff @(posedge clock) begin
        if (!reset && valid && !row_eff[0] && col_eff[0])
            linebuf[lb_addr] <= pair_sum;
    end
`else
    always_comb begin
        result = din;
        emit   = valid & ~row_eff[0] & ~col_eff[0];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            dataout  <= '0;
            validout <= 1'b0;
            rownum   <= '0;
            colnum   <= '0;
        end else begin
            validout <= emit;
            if (emit) begin
                dataout <= result;
                rownum  <= row_eff[10:1];
                colnum  <= col_eff[10:1];
            end
        end
    end

endmodule

// File: tb/tb_downsampler_2x2.sv
// Self-checking bench for downsampler_2x2 on a reduced 16x8 frame with random data and valid gaps.
// Expectations come from a 2D image array and per-block arithmetic; both build variants are covered.
module tb_downsampler_2x2;

    localparam int W = 16;
    localparam int H = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid;
    logic       sof;
    logic [7:0] din;
    logic [7:0] dataout;
    logic       validout;
    logic [9:0] rownum;
    logic [9:0] colnum;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] img [H][W];
    int pulses;
    int last_r;
    int last_c;

    downsampler_2x2 #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_W(8)) dut (
        .clock(clock), .reset(reset), .valid(valid), .sof(sof), .din(din),
        .dataout(dataout), .validout(validout), .rownum(rownum), .colnum(colnum)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_trigger(input int r, input int c);
`ifdef DOWNSAMPLER_AVG_EN
        return (r % 2 == 1) && (c % 2 == 1);
`else
        return (r % 2 == 0) && (c % 2 == 0);
`endif
    endfunction

    function automatic logic [7:0] exp_val(input int r, input int c);
`ifdef DOWNSAMPLER_AVG_EN
        int t;
        t = int'(img[r-1][c-1]) + int'(img[r-1][c]) + int'(img[r][c-1]) + int'(img[r][c]);
        return 8'((t + 2) / 4);
`else
        return img[r][c];
`endif
    endfunction

    task automatic idle();
        valid = 1'b0;
        sof   = 1'($urandom_range(1));
        din   = 8'($urandom);
        @(posedge clock); #1;
        chk("idle_validout", 32'(validout), 32'd0);
    endtask

    task automatic pixel(input int r, input int c, input bit s);
        bit trig;
        trig  = is_trigger(r, c);
        valid = 1'b1;
        sof   = s;
        din   = img[r][c];
        @(posedge clock); #1;
        chk("validout", 32'(validout), 32'(trig));
        if (trig) begin
            pulses++;
            last_r = int'(rownum);
            last_c = int'(colnum);
            chk("dataout", 32'(dataout), 32'(exp_val(r, c)));
            chk("rownum", 32'(rownum), 32'(r / 2));
            chk("colnum", 32'(colnum), 32'(c / 2));
        end
    endtask

    // Drives a frame from (0,0); stops before (stop_r,stop_c) when stop_r >= 0.
    task automatic frame(input bit first_sof, input int gap_pct, input int stop_r, input int stop_c);
        pulses = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                while (int'($urandom_range(99)) < gap_pct) idle();
                pixel(r, c, first_sof && r == 0 && c == 0);
            end
        end
        chk("frame_count", 32'(pulses), 32'((W / 2) * (H / 2)));
        chk("last_rownum", 32'(last_r), 32'(H / 2 - 1));
        chk("last_colnum", 32'(last_c), 32'(W / 2 - 1));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_validout"}, 32'(validout), 32'd0);
        chk({tag, "_dataout"}, 32'(dataout), 32'd0);
        chk({tag, "_rownum"}, 32'(rownum), 32'd0);
        chk({tag, "_colnum"}, 32'(colnum), 32'd0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; sof = 1'b0; din = '0;
        repeat (2) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;

        // Constant frame, gap-free, then a second frame relying on counter wrap.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'h80;
        frame(1'b1, 0, -1, -1);
        frame(1'b0, 0, -1, -1);

        // Alternating 0/1 columns.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(c % 2);
        frame(1'b1, 0, -1, -1);

        // Rounding corner blocks on top of random data.
        fill_random();
        img[0][0] = 8'd1;   img[0][1] = 8'd1;   img[1][0] = 8'd1;   img[1][1] = 8'd0;
        img[0][2] = 8'd0;   img[0][3] = 8'd0;   img[1][2] = 8'd0;   img[1][3] = 8'd1;
        img[0][4] = 8'd255; img[0][5] = 8'd255; img[1][4] = 8'd255; img[1][5] = 8'd255;
        img[0][6] = 8'd0;   img[0][7] = 8'd0;   img[1][6] = 8'd1;   img[1][7] = 8'd1;
        frame(1'b1, 0, -1, -1);

        // Random data with random valid gaps.
        fill_random();
        frame(1'b1, 50, -1, -1);
        fill_random();
        frame(1'b0, 30, -1, -1);

        // Reset mid-frame with valid high: the pixel is dropped, outputs clear.
        fill_random();
        frame(1'b1, 20, 5, 7);
        reset = 1'b1; valid = 1'b1; sof = 1'b0; din = 8'hFF;
        @(posedge clock); #1;
        check_zero_outputs("midreset");
        reset = 1'b0;
        idle();
        check_zero_outputs("postreset");
        fill_random();
        frame(1'b1, 10, -1, -1);

        // sof in the middle of row 3 resynchronises the counters.
        fill_random();
        frame(1'b1, 0, 3, 10);
        fill_random();
        frame(1'b1, 0, -1, -1);

        valid = 1'b0; sof = 1'b0;
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
